// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             mthi_we;
   logic             mtlo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, mthi_we, mtlo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, mthi_we, mtlo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: shift-add multiply, restoring divide,
// operating on magnitudes with a final sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             is_div_q, is_div_d;
   logic             pneg_q, pneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dzp_q, dzp_d;

   logic             sgn_op;
   logic             b_zero;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [2*WIDTH-1:0] prod_fix;

   assign sgn_op = ~bus.op[0];
   assign b_zero = (bus.b == '0);
   assign mag_a  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // acc_lo holds the multiplier (multiply) or the dividend/quotient (divide)
   assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign prod_fix  = pneg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      pneg_d   = pneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dzp_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = (bus.op[1] && b_zero) ? S_FIX : S_RUN;
               cnt_d    = '0;
               acc_hi_d = '0;
               acc_lo_d = mag_a;
               opb_d    = mag_b;
               is_div_d = bus.op[1];
               pneg_d   = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               rneg_d   = sgn_op & bus.a[WIDTH-1];
               dz_d     = bus.op[1] & b_zero;
            end else begin
               if (bus.mthi_we) hi_d = bus.wdata;
               if (bus.mtlo_we) lo_d = bus.wdata;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 6'd1;
            if (is_div_q) begin
               // borrow out of the trial subtract means the divisor did not fit
               if (!div_diff[WIDTH]) begin
                  acc_hi_d = div_diff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = div_shift[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dzp_d   = dz_q;
            if (!dz_q) begin
               if (is_div_q) begin
                  hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                  lo_d = pneg_q ? -acc_lo_q : acc_lo_q;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // flush beats everything, including a same-cycle start or MTHI/MTLO
      if (bus.flush) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         dzp_d   = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         pneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dzp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         pneg_q   <= pneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dzp_q    <= dzp_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dzp_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, divide-by-zero,
// ignored start/MTLO while busy, flush and reset abort.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_bad = 0;

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      tick();
      bus.start = 1'b0;
   endtask

   // Called right after the accepting edge (or c0 edges later); returns edges to done.
   task automatic wait_done(input int c0, output int cyc, output int bcyc);
      cyc  = c0;
      bcyc = 0;
      while (!bus.done && cyc < 100) begin
         if (bus.busy) bcyc++;
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
      int c, bc;
      issue(o, x, y);
      wait_done(0, c, bc);
      chk({tag, "_lat"}, 64'(c), 64'd33);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
      chk({tag, "_dz"}, 64'(bus.div_by_zero), 64'd0);
   endtask

   initial begin
      int c, bc, nd;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.a       = '0;
      bus.b       = '0;
      bus.flush   = 1'b0;
      bus.mthi_we = 1'b0;
      bus.mtlo_we = 1'b0;
      bus.wdata   = '0;
      tick();
      tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      rst_n = 1'b1;
      tick();

      // MULTU max*max with busy-length and pulse-width checks
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0, c, bc);
      chk("multu_lat", 64'(c), 64'd33);
      chk("multu_busy_len", 64'(bc), 64'd33);
      chk("multu_busy_at_done", 64'(bus.busy), 64'd0);
      chk("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(bus.lo), 64'h0000_0001);
      tick();
      chk("multu_done_pulse", 64'(bus.done), 64'd0);

      // these issue back-to-back in each done cycle
      run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

      // MTHI then divide by zero
      tick();
      bus.mthi_we = 1'b1;
      bus.wdata   = 32'h1234;
      tick();
      bus.mthi_we = 1'b0;
      chk("mthi", 64'(bus.hi), 64'h1234);
      issue(2'b11, 32'd5, 32'd0);
      wait_done(0, c, bc);
      chk("dz_lat", 64'(c), 64'd1);
      chk("dz_busy_len", 64'(bc), 64'd1);
      chk("dz_flag", 64'(bus.div_by_zero), 64'd1);
      chk("dz_hi", 64'(bus.hi), 64'h1234);
      chk("dz_lo", 64'(bus.lo), 64'h8000_0000);
      tick();
      chk("dz_pulse", 64'({bus.done, bus.div_by_zero}), 64'd0);

      // start and MTLO while busy are ignored
      issue(2'b01, 32'd6, 32'd7);
      for (int i = 0; i < 9; i++) tick();
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'd99;
      bus.b     = 32'd77;
      tick();
      bus.start   = 1'b0;
      tick();
      bus.mtlo_we = 1'b1;
      bus.wdata   = 32'hDEAD_BEEF;
      tick();
      bus.mtlo_we = 1'b0;
      wait_done(12, c, bc);
      chk("ign_lat", 64'(c), 64'd33);
      chk("ign_hilo", {bus.hi, bus.lo}, {32'd0, 32'd42});
      tick();
      chk("ign_no_restart", 64'(bus.busy), 64'd0);

      // flush mid-multiply
      bus.mthi_we = 1'b1;
      bus.wdata   = 32'h55;
      tick();
      bus.mthi_we = 1'b0;
      issue(2'b01, 32'd9, 32'd9);
      for (int i = 0; i < 15; i++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) nd++;
         tick();
      end
      chk("flush_nodone", 64'(nd), 64'd0);
      chk("flush_hilo", {bus.hi, bus.lo}, {32'h55, 32'd42});
      run_op("post_flush", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

      // reset mid-multiply
      tick();
      issue(2'b01, 32'h1000, 32'h1000);
      for (int i = 0; i < 20; i++) tick();
      rst_n = 1'b0;
      tick();
      chk("rstmid_busy", 64'(bus.busy), 64'd0);
      chk("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) nd++;
         tick();
      end
      chk("rstmid_nodone", 64'(nd), 64'd0);
      run_op("post_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the 64-bit result in HI/LO. The ALU's MFHI/MFLO path reads HI/LO from this block, and the hazard unit stalls on `busy`. It replaces the ALU's single-cycle `a*b` and `a/b` with a sequential shift-add and restoring-divide datapath.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits wide. Only 32 is verified.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new operation. Sampled only in IDLE.
- `op`  in  2: operation select. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`, `b`  in  32 each: operands (rs, rt). Captured on the accepting edge.
- `flush`  in  1: abort any in-progress operation (pipeline flush).
- `mthi_we`, `mtlo_we`  in  1 each: MTHI/MTLO write enables.
- `wdata`  in  32: data for MTHI/MTLO.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse on completion.
- `div_by_zero`  out  1: one-cycle pulse, coincident with `done`, when DIV/DIVU had `b==0`.
- `hi`, `lo`  out  32 each: registered HI/LO. Read by the ALU for MFHI/MFLO.

## Operation
- States:
  - IDLE
  - RUN: 32 iterations, 6-bit counter.
  - FIX: sign correction and HI/LO write.
- IDLE with `start=1` and `flush=0`:
  - Capture magnitudes |a| and |b| for signed ops, raw values for unsigned ops.
  - Record the result sign (product/quotient sign = a[31]^b[31]; remainder sign = a[31]).
  - Clear the counter and go to RUN.
- DIV/DIVU with `b==0`: go directly to FIX with the dz flag set. HI/LO are left unchanged.
- RUN, multiply: each cycle, if multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator (33-bit carry kept), then shift right 1.
- RUN, divide: each cycle, restoring step. Shift {rem, quot} left 1, trial-subtract the divisor from rem, commit if non-negative, and set the quotient LSB.
- RUN exits to FIX after the 32nd iteration.
- FIX:
  - Negate results per the recorded signs (64-bit product; quotient and remainder separately).
  - Write HI/LO: product high/low to HI/LO; remainder to HI, quotient to LO.
  - Pulse `done`; pulse `div_by_zero` if the dz flag is set. In the dz case HI/LO are not written.
  - Return to IDLE.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- `flush=1` in any state:
  - Next state is IDLE, with no `done`, no `div_by_zero`, HI/LO unchanged.
  - Flush has priority over `start` in the same cycle.
- `start` while `busy`: ignored.
- `mthi_we`/`mtlo_we`:
  - Take effect on the edge only in IDLE with `start=0`.
  - Ignored while busy, or when `start` is accepted in the same cycle.
  - Both may be asserted together; both registers then get `wdata`.
- Reset (any state, including mid-operation): state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi` = `lo` = 0; counter and datapath registers = 0.

## Timing
- Edge 0 accepts `start`. `busy`=1 from after edge 0 through edge 33.
- Edges 1..32 are the iterations. Edge 33 is FIX: HI/LO are updated, `done`=1 for the cycle after edge 33, and `busy`=0 in that same cycle.
- Latency: 33 cycles from accepting edge to `done`.
- A new `start` is accepted in the `done` cycle (back-to-back issue: 34-cycle period).
- Divide by zero: edge 0 to FIX, edge 1 completes. `done`/`div_by_zero` high for one cycle after edge 1, and `busy` high for exactly one cycle.
- `hi`/`lo` are registered outputs and never change combinationally. MFHI issued in the `done` cycle sees the new value.
- `busy` is a registered output, derived from state != IDLE.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` 33 cycles after start, HI=0xFFFFFFFE, LO=0x00000001. `busy` high exactly 33 cycles.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI 0x1234 then DIVU 5/0 → `done` and `div_by_zero` 1 cycle after start, HI=0x1234 and LO unchanged.
- MULTU 6×7 started, second `start` with different operands at cycle 10, MTLO at cycle 12 → both ignored. HI=0, LO=42 at cycle 33.
- Stop a multiply mid-operation two ways → `busy` drops next cycle, no `done`, HI/LO keep prior values:
  - `flush` at cycle 15.
  - `rst_n` low at cycle 20 (also HI=LO=0).
  - After either, a following MULTU 2×3 completes correctly (LO=6).
